// File: rtl/cache_controller.sv
// cache_controller: set-associative write-back/write-allocate cache sequencer with true-LRU replacement.
module address_parse #(
  parameter int unsigned AWID = 16,
  parameter int unsigned IW = 8,
  parameter int unsigned BW = 4
) (
  input  logic [AWID-1:0]      addr_i,
  output logic [AWID-IW-BW-1:0] tag_o,
  output logic [IW-1:0]        index_o,
  output logic [BW-1:0]        byte_select_o
);
  assign {tag_o, index_o, byte_select_o} = addr_i;
endmodule

module cache_controller #(
  parameter int unsigned instruction_size = 16,
  parameter int unsigned capacity = 10,
  parameter int unsigned associativity = 4,
  parameter int unsigned data_lines = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [instruction_size-1:0]           req_addr,
  output logic                                  resp_valid,
  output logic                                  resp_hit,
  output logic [$clog2(associativity)-1:0]      resp_way,
  output logic [capacity-$clog2(associativity)-1:0] resp_index,
  output logic                                  mem_req,
  output logic                                  mem_write,
  output logic [instruction_size-1:0]           mem_addr,
  input  logic                                  mem_ack
);
  localparam int unsigned AW = $clog2(associativity);
  localparam int unsigned IW = capacity - AW;
  localparam int unsigned TW = instruction_size - IW - data_lines;
  localparam int unsigned SETS = 1 << IW;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;
  state_t state_q, state_d;
  logic [instruction_size-1:0] addr_q;
  logic write_q, hit_q;
  logic [AW-1:0] victim_q, victim_d, way_q;
  logic [IW-1:0] index_q;
  logic [TW-1:0] tag_q [SETS][associativity];
  logic valid_q [SETS][associativity];
  logic dirty_q [SETS][associativity];
  logic [AW-1:0] age_q [SETS][associativity];
  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [data_lines-1:0] bsel_unused;
  logic hit, has_inv, acc_en;
  logic [AW-1:0] hit_way, inv_way, lru_way, victim, acc_way, acc_age;
  address_parse #(.AWID(instruction_size), .IW(IW), .BW(data_lines)) u_parse (
    .addr_i(addr_q), .tag_o(tag), .index_o(idx), .byte_select_o(bsel_unused)
  );
  // Descending scan leaves the lowest-numbered matching way in each result.
  always_comb begin
    hit = 1'b0;
    has_inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = associativity - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = AW'(w);
      end
      if (age_q[idx][w] == AW'(associativity - 1)) lru_way = AW'(w);
    end
  end
  assign victim = has_inv ? inv_way : lru_way;
  assign acc_en = (state_q == LOOKUP && hit) || (state_q == FILL && mem_ack);
  assign acc_way = (state_q == FILL) ? victim_q : hit_way;
  assign acc_age = age_q[idx][acc_way];
  always_comb begin
    state_d = state_q;
    victim_d = victim_q;
    case (state_q)
      IDLE: state_d = req_valid ? LOOKUP : IDLE;
      LOOKUP: begin
        victim_d = hit ? victim_q : victim;
        state_d = hit ? RESPOND : (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : FILL;
      end
      WRITEBACK: state_d = mem_ack ? FILL : WRITEBACK;
      FILL: state_d = mem_ack ? RESPOND : FILL;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESPOND;
  assign resp_hit = hit_q;
  assign resp_way = way_q;
  assign resp_index = index_q;
  assign mem_req = state_q == WRITEBACK || state_q == FILL;
  assign mem_write = state_q == WRITEBACK;
  assign mem_addr = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx, {data_lines{1'b0}}} :
                    (state_q == FILL) ? {tag, idx, {data_lines{1'b0}}} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      victim_q <= '0;
      hit_q <= 1'b0;
      way_q <= '0;
      index_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < associativity; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w] <= AW'(w);
        end
    end else begin
      state_q <= state_d;
      victim_q <= victim_d;
      if (req_ready && req_valid) begin
        addr_q <= req_addr;
        write_q <= req_write;
      end
      if (acc_en) begin
        for (int w = 0; w < associativity; w++)
          if (AW'(w) == acc_way) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < acc_age) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        dirty_q[idx][acc_way] <= write_q | (state_q == LOOKUP && dirty_q[idx][acc_way]);
        hit_q <= state_q == LOOKUP;
        way_q <= acc_way;
        index_q <= idx;
      end
      if (state_q == FILL && mem_ack) begin
        tag_q[idx][victim_q] <= tag;
        valid_q[idx][victim_q] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed transactions against the cache controller with hand-computed results.
module tb_cache_controller;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0, mem_ack = 1'b0;
  logic [15:0] req_addr = '0;
  logic req_ready, resp_valid, resp_hit, mem_req, mem_write;
  logic [1:0] resp_way;
  logic [7:0] resp_index;
  logic [15:0] mem_addr;
  int n_checks = 0, n_pass = 0;

  cache_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_index(resp_index), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {req_ready, resp_valid, resp_hit, resp_way, resp_index, mem_req, mem_write, mem_addr},
          {1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 16'h0000});
  endtask

  // Request stays asserted until the response is seen, so any acceptance outside IDLE would show up.
  task automatic xact(input string name, input logic w, input logic [15:0] a, input int d,
                      input logic exp_hit, input logic exp_wb, input logic [15:0] wb_addr,
                      input logic [1:0] exp_way, input int exp_lat);
    int lat = -1, pc = 0;
    logic pr = 1'b0, pw = 1'b0, wb_seen = 1'b0, fill_seen = 1'b0, ready_bad = 1'b0, unstable = 1'b0;
    logic [15:0] ph_addr = '0, wba = '0, fa = '0;
    @(negedge clk);
    check({name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (req_ready) ready_bad = 1'b1;
      if (resp_valid) lat = c;
      else if (mem_req) begin
        if (!pr || pw != mem_write) begin
          pc = 0;
          ph_addr = mem_addr;
        end else begin
          pc++;
          if (mem_addr !== ph_addr) unstable = 1'b1;
        end
        if (mem_write) begin
          wb_seen = 1'b1;
          wba = mem_addr;
        end else begin
          fill_seen = 1'b1;
          fa = mem_addr;
        end
        mem_ack = pc >= d;
      end
      pr = mem_req;
      pw = mem_write;
    end
    req_valid = 1'b0;
    mem_ack = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_hit"}, resp_hit, exp_hit);
    check({name, "_way"}, resp_way, exp_way);
    check({name, "_index"}, resp_index, a[11:4]);
    check({name, "_wb_seen"}, wb_seen, exp_wb);
    if (exp_wb) check({name, "_wb_addr"}, wba, wb_addr);
    check({name, "_fill_seen"}, fill_seen, !exp_hit);
    if (!exp_hit) check({name, "_fill_addr"}, fa, {a[15:4], 4'h0});
    check({name, "_busy_not_ready"}, ready_bad, 1'b0);
    check({name, "_mem_addr_stable"}, unstable, 1'b0);
    @(negedge clk);
    check({name, "_resp_one_cycle"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic fill_set();
    xact("w0230", 1'b1, 16'h0230, 0, 1'b0, 1'b0, 16'h0, 2'd0, 3);
    xact("r1230", 1'b0, 16'h1230, 0, 1'b0, 1'b0, 16'h0, 2'd1, 3);
    xact("r2230", 1'b0, 16'h2230, 0, 1'b0, 1'b0, 16'h0, 2'd2, 3);
    xact("r3230", 1'b0, 16'h3230, 0, 1'b0, 1'b0, 16'h0, 2'd3, 3);
  endtask

  initial begin
    do_reset();
    xact("r1234", 1'b0, 16'h1234, 0, 1'b0, 1'b0, 16'h0, 2'd0, 3);
    xact("r1238", 1'b0, 16'h1238, 0, 1'b1, 1'b0, 16'h0, 2'd0, 2);

    do_reset();
    fill_set();
    xact("r4230_dirty", 1'b0, 16'h4230, 0, 1'b0, 1'b1, 16'h0230, 2'd0, 4);

    do_reset();
    fill_set();
    xact("r0230_hit", 1'b0, 16'h0230, 0, 1'b1, 1'b0, 16'h0, 2'd0, 2);
    xact("r5230_clean", 1'b0, 16'h5230, 0, 1'b0, 1'b0, 16'h0, 2'd1, 3);
    xact("r6230_wait", 1'b0, 16'h6230, 5, 1'b0, 1'b0, 16'h0, 2'd2, 8);

    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_idle", {req_ready, mem_req, resp_valid}, 3'b100);
    xact("r6234_hit", 1'b0, 16'h6234, 0, 1'b1, 1'b0, 16'h0, 2'd2, 2);

    do_reset();
    fill_set();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h4230;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wb", {mem_req, mem_write, mem_addr}, {1'b1, 1'b1, 16'h0230});
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    check("abort_idle", {req_ready, mem_req, resp_valid}, 3'b100);
    @(negedge clk);
    check("abort_no_resp", {req_ready, resp_valid}, 2'b10);
    xact("r4230_after_abort", 1'b0, 16'h4230, 0, 1'b0, 1'b0, 16'h0, 2'd0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing controller for a set-associative, write-back, write-allocate cache.
- Accepts one CPU request at a time and splits the address into tag / index / byte_select with the team's address_parse block.
- Holds the tag/valid/dirty store and per-set true-LRU ages, resolves hit or miss, and drives the memory-side writeback and fill handshake.
- The data array is external: it is indexed by resp_index and resp_way.

Parameters:
- instruction_size, 16, address width in bits.
- capacity, 10, log2 of cache capacity in bytes.
- associativity, 4, number of ways; must be a power of 2 and at least 2.
- data_lines, 4, log2 of line size in bytes; this is the byte_select width.
- Derived widths: IW = capacity - log2(associativity); TW = instruction_size - IW - data_lines; AW = log2(associativity).

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  instruction_size  request address.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  1 if the request hit.
- resp_way  out  AW  way holding the line.
- resp_index  out  IW  set index of the line.
- mem_req  out  1  memory transaction request.
- mem_write  out  1  1 = writeback, 0 = fill.
- mem_addr  out  instruction_size  line address; byte_select field forced to 0.
- mem_ack  in  1  memory completes the current transaction.

Behaviour:
- Reset, synchronous:
  - When rst is high at a clock edge, the state goes to IDLE.
  - All valid and dirty bits clear.
  - In every set, way w gets LRU age w.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, resp_index=0, mem_req=0, mem_write=0, mem_addr=0.
  - rst during any state aborts it: mem_req drops the next cycle, any in-flight mem_ack is ignored, and no response is issued.
- State machine:
  - States: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
  - req_ready=1 only in IDLE. req_valid outside IDLE is ignored.
- IDLE:
  - On req_valid, latch req_addr and req_write, then go to LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against all valid ways of the indexed set.
  - Hit: go to RESPOND with resp_hit=1. Update LRU. Set dirty if the request is a write.
  - Miss, victim selection: the lowest-numbered invalid way if any exists; otherwise the way whose age is associativity-1.
  - Miss with a valid and dirty victim: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK:
  - Drive mem_req=1, mem_write=1, mem_addr={victim tag, index, 0}.
  - Hold until mem_ack, then go to FILL.
- FILL:
  - Drive mem_req=1, mem_write=0, mem_addr={req tag, index, 0}.
  - On mem_ack: install the tag, set valid=1, set dirty=req_write, update LRU, go to RESPOND with resp_hit=0.
- RESPOND:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - resp_hit, resp_way and resp_index hold their values until the next response.
- mem_ack rules:
  - mem_ack is sampled only while mem_req=1; mem_ack while mem_req=0 is ignored.
  - mem_ack may arrive in the first cycle that mem_req is asserted.
  - mem_addr and mem_write stay stable while mem_req=1.
- LRU update on access to way a with old age k:
  - age[a] becomes 0.
  - Every way with age < k increments.
  - Other ways are unchanged.
  - Ages stay a permutation of 0..associativity-1.
- Latency, measured from the acceptance edge:
  - Hit: resp_valid at cycle +2.
  - Clean miss: resp_valid at cycle +3 plus fill wait cycles.
  - Dirty miss: additionally adds the writeback cycles.
- Back-to-back: a new request can be accepted the cycle after resp_valid.

Test Plan (defaults: IW=8, TW=4, AW=2; address 0x1234 gives tag 0x1, index 0x23, byte_select 0x4):
- Reset, then read 0x1234 with mem_ack returned immediately: mem_req=1, mem_write=0, mem_addr=0x1230. Then resp_valid=1, resp_hit=0, resp_way=0, resp_index=0x23.
- Read 0x1238 next: no mem_req; resp_valid exactly 2 cycles after acceptance; resp_hit=1, resp_way=0.
- Reset, then write 0x0230 followed by reads of 0x1230, 0x2230, 0x3230: these fill ways 0, 1, 2, 3 in order. Then read 0x4230:
  - WRITEBACK first: mem_write=1, mem_addr=0x0230.
  - Then FILL: mem_write=0, mem_addr=0x4230.
  - Response: resp_way=0, resp_hit=0.
- Reset, fill ways 0..3 as above, read 0x0230 (hit, way 0), then read 0x5230: victim is way 1 and it is clean. A single FILL with mem_addr=0x5230 follows; resp_way=1.
- Hold mem_ack low for 5 cycles in FILL while req_valid stays high: mem_req and mem_addr stay stable, and req_ready=0 throughout. A stray mem_ack pulse asserted while in IDLE causes no state change.
- Assert rst during WRITEBACK: the next cycle shows req_ready=1 and mem_req=0, with no resp_valid. A subsequent read of the same address misses.
